// File: rtl/vga_layer_compositor_if.sv
// vga_layer_compositor_if: pixel/sync/mask bundle between the layer generators and the compositor.
// Collision ports exist only when VGA_LAYER_COLLISION_EN is defined.
interface vga_layer_compositor_if #(
   parameter int N_LAYERS = 10,
   parameter int COLOR_W  = 12,
   parameter int IDX_W    = 4
);
   logic                         de_in;
   logic                         hs_in;
   logic                         vs_in;
   logic [N_LAYERS*COLOR_W-1:0]  layer_data;
   logic [COLOR_W-1:0]           bg_color;
   logic                         mask_wr;
   logic [N_LAYERS-1:0]          mask_din;
   logic [COLOR_W-1:0]           pix_out;
   logic                         de_out;
   logic                         hs_out;
   logic                         vs_out;
   logic                         hit_valid;
   logic [IDX_W-1:0]             hit_idx;
   logic [N_LAYERS-1:0]          mask_active;
`ifdef VGA_LAYER_COLLISION_EN
   logic                         collision;
   logic [15:0]                  collision_cnt;
`endif
   modport master (
      output de_in, hs_in, vs_in, layer_data, bg_color, mask_wr, mask_din,
`ifdef VGA_LAYER_COLLISION_EN
      input  collision, collision_cnt,
`endif
      input  pix_out, de_out, hs_out, vs_out, hit_valid, hit_idx, mask_active
   );
   modport slave (
      input  de_in, hs_in, vs_in, layer_data, bg_color, mask_wr, mask_din,
`ifdef VGA_LAYER_COLLISION_EN
      output collision, collision_cnt,
`endif
      output pix_out, de_out, hs_out, vs_out, hit_valid, hit_idx, mask_active
   );
endinterface

// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: 2-stage fixed-priority colour-key compositor with frame-synchronous layer mask.
// Optional collision detect/count enabled by defining VGA_LAYER_COLLISION_EN.
module vga_layer_compositor #(
   parameter int                   N_LAYERS   = 10,
   parameter int                   COLOR_W    = 12,
   parameter logic [COLOR_W-1:0]   TRANSP_KEY = '0,
   parameter bit                   VS_POL     = 1'b0,
   parameter int                   IDX_W      = 4
) (
   input logic                    clk,
   input logic                    rst,
   vga_layer_compositor_if.slave  bus
);
   localparam logic IDLE = ~VS_POL;
   logic [N_LAYERS*COLOR_W-1:0] data1;
   logic [COLOR_W-1:0]          bg1, win_pix;
   logic                        de1, hs1, vs1, vs_prev, hit, frame_start;
   logic [N_LAYERS-1:0]         vis, vis1, pend, mask;
   logic [IDX_W-1:0]            win;
   assign frame_start = (bus.vs_in == VS_POL) && (vs_prev != VS_POL);
   assign hit = |vis1;
   assign bus.mask_active = mask;
   always_comb begin
      vis = '0;
      for (int i = 0; i < N_LAYERS; i++)
         vis[i] = mask[i] && (bus.layer_data[i*COLOR_W +: COLOR_W] != TRANSP_KEY);
   end
   // Scan downward so the lowest visible index is the last one written.
   always_comb begin
      win = '0;
      win_pix = '0;
      for (int i = N_LAYERS - 1; i >= 0; i--)
         if (vis1[i]) begin
            win = IDX_W'(i);
            win_pix = data1[i*COLOR_W +: COLOR_W];
         end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         data1         <= '0;
         bg1           <= '0;
         de1           <= 1'b0;
         hs1           <= IDLE;
         vs1           <= IDLE;
         vis1          <= '0;
         vs_prev       <= IDLE;
         pend          <= '1;
         mask          <= '1;
         bus.pix_out   <= '0;
         bus.hit_valid <= 1'b0;
         bus.hit_idx   <= '0;
         bus.de_out    <= 1'b0;
         bus.hs_out    <= IDLE;
         bus.vs_out    <= IDLE;
      end else begin
         data1         <= bus.layer_data;
         bg1           <= bus.bg_color;
         de1           <= bus.de_in;
         hs1           <= bus.hs_in;
         vs1           <= bus.vs_in;
         vis1          <= vis;
         vs_prev       <= bus.vs_in;
         pend          <= bus.mask_wr ? bus.mask_din : pend;
         mask          <= frame_start ? (bus.mask_wr ? bus.mask_din : pend) : mask;
         bus.pix_out   <= !de1 ? '0 : hit ? win_pix : bg1;
         bus.hit_valid <= de1 && hit;
         bus.hit_idx   <= (de1 && hit) ? win : '0;
         bus.de_out    <= de1;
         bus.hs_out    <= hs1;
         bus.vs_out    <= vs1;
      end
   end
`ifdef VGA_LAYER_COLLISION_EN
   logic [15:0] ccnt;
   logic        col;
   assign col = de1 && ((vis1 & (vis1 - N_LAYERS'(1))) != '0);
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.collision     <= 1'b0;
         bus.collision_cnt <= '0;
         ccnt              <= '0;
      end else begin
         bus.collision <= col;
         if (frame_start) begin
            bus.collision_cnt <= ccnt;
            ccnt              <= {15'b0, col};
         end else if (col && ccnt != 16'hFFFF)
            ccnt <= ccnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_vga_layer_compositor.sv
// tb_vga_layer_compositor: directed vectors with hand-computed expectations for the default 10x12-bit build.
module tb_vga_layer_compositor;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic hh [0:39];
   logic vh [0:39];
   logic dh [0:39];
   vga_layer_compositor_if bus ();
   vga_layer_compositor dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic lay(input int i, input logic [11:0] v);
      bus.layer_data[i*12 +: 12] = v;
   endtask
   initial begin
      rst = 1'b1;
      bus.de_in = 1'b0;
      bus.hs_in = 1'b1;
      bus.vs_in = 1'b1;
      bus.layer_data = '0;
      bus.bg_color = 12'h111;
      bus.mask_wr = 1'b0;
      bus.mask_din = '0;
      step();
      step();
      check("rst_pix", 32'(bus.pix_out), 32'h0);
      check("rst_hv", 32'(bus.hit_valid), 32'h0);
      check("rst_idx", 32'(bus.hit_idx), 32'h0);
      check("rst_de", 32'(bus.de_out), 32'h0);
      check("rst_hs", 32'(bus.hs_out), 32'h1);
      check("rst_vs", 32'(bus.vs_out), 32'h1);
      check("rst_mask", 32'(bus.mask_active), 32'h3FF);
      rst = 1'b0;
      bus.de_in = 1'b1;
      lay(3, 12'h0F0);
      step();
      check("lat1_pix", 32'(bus.pix_out), 32'h0);
      step();
      check("l3_pix", 32'(bus.pix_out), 32'h0F0);
      check("l3_hv", 32'(bus.hit_valid), 32'h1);
      check("l3_idx", 32'(bus.hit_idx), 32'h3);
      bus.layer_data = '0;
      lay(2, 12'hF00);
      lay(5, 12'h00F);
      step();
      step();
      check("pri_pix", 32'(bus.pix_out), 32'hF00);
      check("pri_idx", 32'(bus.hit_idx), 32'h2);
      lay(2, 12'h000);
      step();
      step();
      check("l5_pix", 32'(bus.pix_out), 32'h00F);
      check("l5_idx", 32'(bus.hit_idx), 32'h5);
      bus.layer_data = '0;
      step();
      step();
      check("bg_pix", 32'(bus.pix_out), 32'h111);
      check("bg_hv", 32'(bus.hit_valid), 32'h0);
      lay(2, 12'hF00);
      bus.de_in = 1'b0;
      step();
      step();
      check("blank_pix", 32'(bus.pix_out), 32'h0);
      check("blank_hv", 32'(bus.hit_valid), 32'h0);
      check("blank_de", 32'(bus.de_out), 32'h0);
      bus.layer_data = '0;
      for (int c = 0; c < 40; c++) begin
         bus.hs_in = !(c >= 10 && c < 16);
         bus.vs_in = !(c >= 20 && c < 23);
         bus.de_in = (c % 3) != 0;
         hh[c] = bus.hs_in;
         vh[c] = bus.vs_in;
         dh[c] = bus.de_in;
         step();
         if (c > 0) begin
            check("hs_dly", 32'(bus.hs_out), 32'(hh[c-1]));
            check("vs_dly", 32'(bus.vs_out), 32'(vh[c-1]));
            check("de_dly", 32'(bus.de_out), 32'(dh[c-1]));
         end
      end
      bus.hs_in = 1'b1;
      bus.vs_in = 1'b1;
      bus.de_in = 1'b1;
`ifdef VGA_LAYER_COLLISION_EN
      begin
         int sum;
         sum = 0;
         for (int c = 0; c < 10; c++) begin
            bus.layer_data = '0;
            if (c < 5) begin
               lay(0, 12'h001);
               lay(1, 12'h002);
            end
            step();
            sum += 32'(bus.collision);
         end
         check("col_pulses", 32'(sum), 32'd5);
         bus.vs_in = 1'b0;
         step();
         check("col_cnt", 32'(bus.collision_cnt), 32'd5);
         bus.vs_in = 1'b1;
         step();
         bus.vs_in = 1'b0;
         step();
         check("col_cnt_clr", 32'(bus.collision_cnt), 32'd0);
         bus.vs_in = 1'b1;
         step();
      end
`endif
      bus.layer_data = '0;
      step();
      bus.mask_wr = 1'b1;
      bus.mask_din = 10'h3FB;
      step();
      bus.mask_wr = 1'b0;
      lay(2, 12'hF00);
      lay(5, 12'h00F);
      step();
      check("defer_mask", 32'(bus.mask_active), 32'h3FF);
      step();
      check("defer_pix", 32'(bus.pix_out), 32'hF00);
      bus.vs_in = 1'b0;
      step();
      check("edge_mask", 32'(bus.mask_active), 32'h3FB);
      bus.vs_in = 1'b1;
      step();
      step();
      step();
      check("mask_pix", 32'(bus.pix_out), 32'h00F);
      check("mask_idx", 32'(bus.hit_idx), 32'h5);
      bus.mask_wr = 1'b1;
      bus.mask_din = 10'h155;
      step();
      bus.mask_din = 10'h3FE;
      step();
      bus.mask_wr = 1'b0;
      bus.vs_in = 1'b0;
      step();
      check("last_wr", 32'(bus.mask_active), 32'h3FE);
      bus.vs_in = 1'b1;
      step();
      bus.vs_in = 1'b0;
      bus.mask_wr = 1'b1;
      bus.mask_din = 10'h000;
      step();
      bus.mask_wr = 1'b0;
      bus.vs_in = 1'b1;
      check("zero_mask", 32'(bus.mask_active), 32'h0);
      step();
      step();
      step();
      check("zero_pix", 32'(bus.pix_out), 32'h111);
      check("zero_hv", 32'(bus.hit_valid), 32'h0);
      bus.vs_in = 1'b0;
      step();
      check("zero_pend", 32'(bus.mask_active), 32'h0);
      bus.vs_in = 1'b1;
      bus.hs_in = 1'b0;
      bus.mask_wr = 1'b1;
      bus.mask_din = 10'h005;
      step();
      bus.mask_wr = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("mrst_pix", 32'(bus.pix_out), 32'h0);
      check("mrst_hv", 32'(bus.hit_valid), 32'h0);
      check("mrst_de", 32'(bus.de_out), 32'h0);
      check("mrst_hs", 32'(bus.hs_out), 32'h1);
      check("mrst_vs", 32'(bus.vs_out), 32'h1);
      check("mrst_mask", 32'(bus.mask_active), 32'h3FF);
      rst = 1'b0;
      bus.hs_in = 1'b1;
      step();
      bus.vs_in = 1'b0;
      step();
      check("pend_drop", 32'(bus.mask_active), 32'h3FF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
- Parametrised successor to the 10-input, 12-bit OR-combining VGA data selector.
- Merges N_LAYERS colour layers into one VGA pixel stream using fixed priority: layer 0 is on top, and a layer is transparent where its pixel equals TRANSP_KEY.
- Adds a per-layer enable mask that updates only at frame boundaries, a background colour, and a 2-stage registered pipeline that keeps sync/DE aligned.
- Sits between the sprite/scene generators and the VGA timing output.

Parameters:
- N_LAYERS, 10, number of input layers (2..16).
- COLOR_W, 12, bits per pixel (RGB444 default).
- TRANSP_KEY, 0, pixel value treated as transparent.
- VS_POL, 0, active level of vs_in (0 = active-low).
- IDX_W, 4, width of the hit-index output; must satisfy 2^IDX_W >= N_LAYERS.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- de_in  in  1  display enable, aligned with layer_data
- hs_in  in  1  hsync, aligned with layer_data
- vs_in  in  1  vsync, aligned with layer_data
- layer_data  in  N_LAYERS*COLOR_W  concatenated layers; layer i occupies bits [i*COLOR_W +: COLOR_W]
- bg_color  in  COLOR_W  colour used when no layer is visible
- mask_wr  in  1  write strobe for the pending layer mask
- mask_din  in  N_LAYERS  new mask value; bit i = 1 enables layer i
- pix_out  out  COLOR_W  composited pixel
- de_out  out  1  de_in delayed by 2 cycles
- hs_out  out  1  hs_in delayed by 2 cycles
- vs_out  out  1  vs_in delayed by 2 cycles
- hit_valid  out  1  1 when some layer supplied the pixel
- hit_idx  out  IDX_W  index of the supplying layer; 0 when hit_valid = 0
- mask_active  out  N_LAYERS  layer mask currently in force

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on clk rising edge.
- Reset values:
  - pix_out = 0, hit_valid = 0, hit_idx = 0, de_out = 0.
  - hs_out = vs_out = 1 if VS_POL = 0, else 0.
  - mask_active = all-ones; pending mask = all-ones; vs edge detector = inactive level.
- Stage 1 (registered):
  - Capture layer_data, bg_color, de_in, hs_in, vs_in.
  - Compute vis[i] = mask_active[i] & (layer_i != TRANSP_KEY), using mask_active as it was before that edge.
- Stage 2 (registered):
  - Priority encode vis, lowest index wins.
  - If the registered de = 0: pix_out = 0, hit_valid = 0, hit_idx = 0.
  - Else if some vis bit is set: pix_out = winning layer's pixel, hit_valid = 1, hit_idx = winner index.
  - Else: pix_out = stage-1 registered bg_color, hit_valid = 0, hit_idx = 0.
- Latency: exactly 2 cycles from inputs to all outputs. Sync and DE delays match the pixel path.
- Mask update:
  - mask_wr = 1 loads mask_din into the pending register.
  - mask_active takes the pending value on the cycle in which vs_in transitions from inactive to active (frame-start edge).
  - mask_wr coinciding with that edge: mask_din goes straight to mask_active and to pending.
  - Multiple writes within a frame: the last one wins.
- All-zero mask: every pixel shows bg_color; legal.
- TRANSP_KEY equal to bg_color: legal, no special case.
- Reset mid-frame: pipeline flushes, outputs go to reset values, and a pending mask is discarded (back to all-ones).

Optional Feature:
- Macro: VGA_LAYER_COLLISION_EN.
- When defined, two ports are added:
  - collision out 1: stage-2 registered; 1 when de is high and two or more vis bits are set.
  - collision_cnt out 16: frame collision count.
- An internal 16-bit counter increments on each collision pixel and saturates at 0xFFFF.
- On the frame-start vs edge, the counter value is copied to collision_cnt and the counter clears to 0; if that cycle is itself a collision, the counter becomes 1.
- Reset clears collision, collision_cnt and the counter to 0.
- When not defined: those ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then defaults: de_in = 1, layer 3 = 0x0F0, all other layers = 0, bg_color = 0x111 → 2 cycles later pix_out = 0x0F0, hit_valid = 1, hit_idx = 3.
- Priority: layer 2 = 0xF00 and layer 5 = 0x00F in the same cycle → pix_out = 0xF00, hit_idx = 2. With layer 2 then set to 0 → pix_out = 0x00F, hit_idx = 5.
- Blanking: de_in = 0 with non-zero layers → pix_out = 0 and hit_valid = 0. Check hs_out/vs_out equal hs_in/vs_in delayed by exactly 2 cycles over a full line.
- Deferred mask: mask_wr with mask_din = 0x3FB (layer 2 off) mid-frame → mask_active stays 0x3FF until the vs_in falling edge (VS_POL = 0), then reads 0x3FB. Layer 2 = 0xF00, layer 5 = 0x00F → pix_out = 0x00F.
- Boundaries:
  - mask_wr = 0x000 on the same cycle as the vs edge → mask_active = 0x000 the next cycle, and pix_out = bg_color while de is high.
  - rst asserted mid-frame → all outputs at reset values the next cycle, mask_active = 0x3FF.
- Collision (macro defined): layers 0 and 1 non-zero for 5 de-high pixels in one frame → collision pulses 5 times; collision_cnt = 5 after the next frame-start edge, then the counter restarts from 0.
